// File: rtl/alu_op_sequencer.sv
// Purpose    : shares one ALU between two requesters; round-robin grant, drives the ALU, returns a tagged response.
// Latency    : response valid ALU_LAT+1 cycles after the request transfer (1 cycle for a divide-by-zero reject).
// Backpressure: one operation in flight; no request is accepted until the response handshakes on rsp_ready.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   req{0,1}_valid/_ready/_op/_a/_b requester handshakes; ready is combinational, high only in IDLE for the grant
//   alu_sel, alu_a, alu_b           registered ALU inputs, held for the whole EXEC phase
//   alu_result, alu_carry           ALU outputs, sampled when the settle counter expires
//   rsp_valid/_ready/_id/_data/_zero/_carry/_err   tagged response handshake
//   busy                            high whenever the FSM is not IDLE
//   stat_cnt0, stat_cnt1            per-requester completion counters
// Build option: define ALU_SEQ_STATS_EN to build the saturating completion counters; otherwise they read 0.
module alu_op_sequencer #(
    parameter int DW      = 8,
    parameter int ALU_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [3:0]    req0_op,
    input  logic [DW-1:0] req0_a,
    input  logic [DW-1:0] req0_b,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [3:0]    req1_op,
    input  logic [DW-1:0] req1_a,
    input  logic [DW-1:0] req1_b,
    output logic [3:0]    alu_sel,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    input  logic [DW-1:0] alu_result,
    input  logic          alu_carry,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_id,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_zero,
    output logic          rsp_carry,
    output logic          rsp_err,
    output logic          busy,
    output logic [15:0]   stat_cnt0,
    output logic [15:0]   stat_cnt1
);

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_DIV = 4'b0011;
    localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

    state_t        state_q, state_d;
    logic          ptr_q, ptr_d;
    logic          id_q, id_d;
    logic [3:0]    op_q, op_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [3:0]    alu_sel_q, alu_sel_d;
    logic [DW-1:0] alu_a_q, alu_a_d;
    logic [DW-1:0] alu_b_q, alu_b_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_id_q, rsp_id_d;
    logic [DW-1:0] rsp_data_q, rsp_data_d;
    logic          rsp_zero_q, rsp_zero_d;
    logic          rsp_carry_q, rsp_carry_d;
    logic          rsp_err_q, rsp_err_d;

    logic          grant;
    logic          xfer;
    logic [3:0]    gnt_op;
    logic [DW-1:0] gnt_a, gnt_b;

    // Arbitration: pointer only matters when both ask. Transfers are blocked
    // while rst is high so nothing is acknowledged that reset will discard.
    always_comb begin
        grant      = (req0_valid && req1_valid) ? ptr_q : req1_valid;
        xfer       = (state_q == IDLE) && !rst && (req0_valid || req1_valid);
        req0_ready = xfer && !grant;
        req1_ready = xfer && grant;
        gnt_op     = grant ? req1_op : req0_op;
        gnt_a      = grant ? req1_a  : req0_a;
        gnt_b      = grant ? req1_b  : req0_b;
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        alu_sel_d   = alu_sel_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_zero_d  = rsp_zero_q;
        rsp_carry_d = rsp_carry_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    op_d = gnt_op;
                    id_d = grant;
                    if (gnt_op == OP_DIV && gnt_b == '0) begin
                        // Reject without touching the ALU inputs.
                        rsp_valid_d = 1'b1;
                        rsp_id_d    = grant;
                        rsp_data_d  = '0;
                        rsp_zero_d  = 1'b1;
                        rsp_carry_d = 1'b0;
                        rsp_err_d   = 1'b1;
                        state_d     = RESP;
                    end else begin
                        alu_sel_d = gnt_op;
                        alu_a_d   = gnt_a;
                        alu_b_d   = gnt_b;
                        cnt_d     = LAT_M1;
                        state_d   = EXEC;
                    end
                end
            end
            EXEC: begin
                if (cnt_q == 4'd0) begin
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id_q;
                    rsp_data_d  = alu_result;
                    rsp_zero_d  = (alu_result == '0);
                    // Carry is only meaningful for add/sub.
                    rsp_carry_d = alu_carry && (op_q == OP_ADD || op_q == OP_SUB);
                    rsp_err_d   = 1'b0;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    ptr_d       = ~rsp_id_q;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b0;
            id_q        <= 1'b0;
            op_q        <= '0;
            cnt_q       <= '0;
            alu_sel_q   <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
            rsp_zero_q  <= 1'b0;
            rsp_carry_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            alu_sel_q   <= alu_sel_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_zero_q  <= rsp_zero_d;
            rsp_carry_q <= rsp_carry_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign alu_sel   = alu_sel_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_zero  = rsp_zero_q;
    assign rsp_carry = rsp_carry_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = (state_q != IDLE);

`ifdef ALU_SEQ_STATS_EN
    logic [15:0] stat_cnt0_q, stat_cnt1_q;
    logic        rsp_hs;

    assign rsp_hs = (state_q == RESP) && rsp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_cnt0_q <= '0;
            stat_cnt1_q <= '0;
        end else if (rsp_hs) begin
            if (!rsp_id_q && stat_cnt0_q != 16'hFFFF) stat_cnt0_q <= stat_cnt0_q + 16'd1;
            if (rsp_id_q && stat_cnt1_q != 16'hFFFF)  stat_cnt1_q <= stat_cnt1_q + 16'd1;
        end
    end

    assign stat_cnt0 = stat_cnt0_q;
    assign stat_cnt1 = stat_cnt1_q;
`else
    assign stat_cnt0 = 16'd0;
    assign stat_cnt1 = 16'd0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Purpose    : self-checking bench for alu_op_sequencer with a transaction-level reference model and ALU model.
// Latency    : expects responses ALU_LAT+1 cycles after transfer, 1 cycle for divide-by-zero.
// Backpressure: drives rsp_ready low for stretches and checks that responses hold and no request is accepted.
module tb_alu_op_sequencer;
    localparam int DW  = 8;
    localparam int LAT = 3;

    typedef struct packed {
        logic       v;
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } req_t;

    typedef struct packed {
        logic       id;
        logic [7:0] data;
        logic       zero;
        logic       carry;
        logic       err;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b0;
    logic req0_ready, req1_ready;
    logic [3:0] req0_op = '0, req1_op = '0;
    logic [DW-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [3:0] alu_sel;
    logic [DW-1:0] alu_a, alu_b, alu_result, rsp_data;
    logic alu_carry, rsp_valid, rsp_id, rsp_zero, rsp_carry, rsp_err, busy;
    logic [15:0] stat_cnt0, stat_cnt1;

    alu_op_sequencer #(.DW(DW), .ALU_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_zero(rsp_zero), .rsp_carry(rsp_carry), .rsp_err(rsp_err), .busy(busy),
        .stat_cnt0(stat_cnt0), .stat_cnt1(stat_cnt1)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: returns {carry, result}.
    function automatic logic [8:0] ref_alu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0]  s;
        logic [8:0]  d;
        logic [15:0] p;
        logic [7:0]  r;
        s = {1'b0, a} + {1'b0, b};
        d = {1'b0, a} - {1'b0, b};
        p = 16'(a) * 16'(b);
        case (op)
            4'd0:  r = s[7:0];
            4'd1:  r = d[7:0];
            4'd2:  r = p[7:0];
            4'd3:  r = (b == 8'd0) ? 8'd0 : a / b;
            4'd4:  r = a << 1;
            4'd5:  r = a >> 1;
            4'd6:  r = {a[6:0], a[7]};
            4'd7:  r = {a[0], a[7:1]};
            4'd8:  r = a & b;
            4'd9:  r = a | b;
            4'd10: r = a ^ b;
            4'd11: r = ~(a | b);
            4'd12: r = ~(a & b);
            4'd13: r = ~(a ^ b);
            4'd14: r = (a > b) ? 8'd1 : 8'd0;
            default: r = (a == b) ? 8'd1 : 8'd0;
        endcase
        return {(op == 4'd1) ? d[8] : s[8], r};
    endfunction

    always_comb {alu_carry, alu_result} = ref_alu(alu_sel, alu_a, alu_b);

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model state: one transaction in flight at most.
    logic       m_busy = 1'b0;
    logic       m_ptr  = 1'b0;
    int         m_due  = 0;
    rsp_t       m_rsp  = '0;
    logic [3:0] m_sel  = '0;
    logic [7:0] m_a    = '0;
    logic [7:0] m_b    = '0;
    int         m_cnt0 = 0;
    int         m_cnt1 = 0;
    rsp_t       hs_log[$];

    localparam req_t NOREQ = '0;

    function automatic req_t mk(input logic v, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        return {v, op, a, b};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: drive at the falling edge, check, then advance the model
    // by what the next rising edge will do.
    task automatic step(input logic r, input req_t q0, input req_t q1, input logic rr);
        logic g, e_r0, e_r1, e_rv;
        logic [8:0] res;
        req_t qg;
        @(negedge clk);
        rst = r;
        req0_valid = q0.v; req0_op = q0.op; req0_a = q0.a; req0_b = q0.b;
        req1_valid = q1.v; req1_op = q1.op; req1_a = q1.a; req1_b = q1.b;
        rsp_ready = rr;
        #1;
        g    = (q0.v && q1.v) ? m_ptr : q1.v;
        e_r0 = !r && !m_busy && q0.v && !g;
        e_r1 = !r && !m_busy && q1.v && g;
        e_rv = m_busy && (cyc >= m_due);
        chk("req0_ready", 32'(req0_ready), 32'(e_r0));
        chk("req1_ready", 32'(req1_ready), 32'(e_r1));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
        if (e_rv && rsp_valid) begin
            chk("rsp_id", 32'(rsp_id), 32'(m_rsp.id));
            chk("rsp_data", 32'(rsp_data), 32'(m_rsp.data));
            chk("rsp_zero", 32'(rsp_zero), 32'(m_rsp.zero));
            chk("rsp_carry", 32'(rsp_carry), 32'(m_rsp.carry));
            chk("rsp_err", 32'(rsp_err), 32'(m_rsp.err));
        end
        chk("alu_sel", 32'(alu_sel), 32'(m_sel));
        chk("alu_a", 32'(alu_a), 32'(m_a));
        chk("alu_b", 32'(alu_b), 32'(m_b));
        chk("stat_cnt0", 32'(stat_cnt0), 32'(m_cnt0));
        chk("stat_cnt1", 32'(stat_cnt1), 32'(m_cnt1));
        if (r) begin
            m_busy = 1'b0; m_ptr = 1'b0; m_sel = '0; m_a = '0; m_b = '0;
            m_cnt0 = 0; m_cnt1 = 0;
        end else if (!m_busy && (q0.v || q1.v)) begin
            qg = g ? q1 : q0;
            m_busy = 1'b1;
            m_rsp.id = g;
            if (qg.op == 4'd3 && qg.b == 8'd0) begin
                m_rsp.data = '0; m_rsp.zero = 1'b1; m_rsp.carry = 1'b0; m_rsp.err = 1'b1;
                m_due = cyc + 1;
            end else begin
                res = ref_alu(qg.op, qg.a, qg.b);
                m_rsp.data  = res[7:0];
                m_rsp.zero  = (res[7:0] == 8'd0);
                m_rsp.carry = res[8] && (qg.op == 4'd0 || qg.op == 4'd1);
                m_rsp.err   = 1'b0;
                m_due = cyc + 1 + LAT;
                m_sel = qg.op; m_a = qg.a; m_b = qg.b;
            end
        end else if (e_rv && rr) begin
            m_busy = 1'b0;
            m_ptr  = ~m_rsp.id;
            hs_log.push_back({rsp_id, rsp_data, rsp_zero, rsp_carry, rsp_err});
`ifdef ALU_SEQ_STATS_EN
            if (m_rsp.id) begin if (m_cnt1 < 65535) m_cnt1++; end
            else          begin if (m_cnt0 < 65535) m_cnt0++; end
`endif
        end
        cyc++;
    endtask

    // Steps until rsp_valid is seen; at = that cycle index, or -1 on timeout.
    task automatic wait_rsp(input req_t q0, input req_t q1, input logic rr, output int at);
        at = -1;
        for (int i = 0; i < 40 && at < 0; i++) begin
            step(1'b0, q0, q1, rr);
            if (rsp_valid) at = cyc - 1;
        end
    endtask

    initial begin
        int t, at;
        req_t ra, rb;
        @(posedge clk);

        // Reset with both requesters asking: nothing may be acknowledged.
        repeat (3) step(1'b1, mk(1, 4'd0, 8'd1, 8'd1), mk(1, 4'd1, 8'd1, 8'd1), 1'b1);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_rsp_flags", 32'({rsp_id, rsp_zero, rsp_carry, rsp_err}), 32'd0);

        // Single add 3+5.
        step(1'b0, mk(1, 4'd0, 8'd3, 8'd5), NOREQ, 1'b1);
        t = cyc - 1;
        step(1'b0, NOREQ, NOREQ, 1'b1);
        chk("add_alu_a", 32'(alu_a), 32'd3);
        chk("add_alu_b", 32'(alu_b), 32'd5);
        wait_rsp(NOREQ, NOREQ, 1'b1, at);
        chk("add_latency", 32'(at - t), 32'(1 + LAT));
        chk("add_data", 32'(rsp_data), 32'd8);
        chk("add_id_zero_carry", 32'({rsp_id, rsp_zero, rsp_carry}), 32'd0);

        // Arbitration: both valid continuously.
        step(1'b1, NOREQ, NOREQ, 1'b0);
        hs_log.delete();
        ra = mk(1, 4'd0, 8'd200, 8'd100);
        rb = mk(1, 4'd1, 8'd2, 8'd3);
        for (int i = 0; i < 80 && hs_log.size() < 4; i++) step(1'b0, ra, rb, 1'b1);
        chk("arb_count", 32'(hs_log.size()), 32'd4);
        for (int i = 0; i < hs_log.size() && i < 4; i++) begin
            chk("arb_id", 32'(hs_log[i].id), 32'(i % 2));
            chk("arb_data", 32'(hs_log[i].data), (i % 2 == 1) ? 32'hFF : 32'd44);
            chk("arb_carry", 32'(hs_log[i].carry), 32'd1);
        end

        // Divide by zero from requester 1: immediate reject, ALU untouched.
        step(1'b0, NOREQ, mk(1, 4'd3, 8'd7, 8'd0), 1'b1);
        t = cyc - 1;
        wait_rsp(NOREQ, NOREQ, 1'b1, at);
        chk("div0_latency", 32'(at - t), 32'd1);
        chk("div0_err", 32'(rsp_err), 32'd1);
        chk("div0_data", 32'(rsp_data), 32'd0);
        chk("div0_zero", 32'(rsp_zero), 32'd1);
        chk("div0_alu_sel", 32'(alu_sel), 32'd1);

        // Backpressure: AND held for 5 cycles, requester 1 kept waiting.
        rb = mk(1, 4'd9, 8'h11, 8'h22);
        step(1'b0, mk(1, 4'd8, 8'hF0, 8'h3C), rb, 1'b0);
        wait_rsp(NOREQ, rb, 1'b0, at);
        chk("bp_seen", 32'(at >= 0), 32'd1);
        repeat (5) begin
            step(1'b0, NOREQ, rb, 1'b0);
            chk("bp_data", 32'(rsp_data), 32'h30);
            chk("bp_ready1", 32'(req1_ready), 32'd0);
        end
        step(1'b0, NOREQ, rb, 1'b1);
        step(1'b0, NOREQ, NOREQ, 1'b1);
        chk("bp_idle", 32'(busy), 32'd0);
        step(1'b0, NOREQ, rb, 1'b1);
        wait_rsp(NOREQ, NOREQ, 1'b1, at);

        // Reset in the second EXEC cycle: operation vanishes.
        step(1'b0, mk(1, 4'd0, 8'd9, 8'd9), NOREQ, 1'b1);
        step(1'b0, NOREQ, NOREQ, 1'b1);
        step(1'b1, NOREQ, NOREQ, 1'b1);
        chk("rst_exec_stat0", 32'(stat_cnt0), 32'd0);
        chk("rst_exec_stat1", 32'(stat_cnt1), 32'd0);
        step(1'b0, NOREQ, mk(1, 4'd10, 8'hA5, 8'h0F), 1'b1);
        chk("rst_exec_grant1", 32'(req1_ready), 32'd1);
        wait_rsp(NOREQ, NOREQ, 1'b1, at);
        chk("rst_exec_rsp", 32'({rsp_id, rsp_data}), 32'({1'b1, 8'hAA}));

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            ra = mk(1'($urandom), 4'($urandom), 8'($urandom), ($urandom % 5 == 0) ? 8'd0 : 8'($urandom));
            rb = mk(1'($urandom), 4'($urandom), 8'($urandom), ($urandom % 5 == 0) ? 8'd0 : 8'($urandom));
            step(($urandom % 250) == 0, ra, rb, ($urandom % 3) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
endmodule
